// File: rtl/ni_cmdq_if.sv
// Bus bundle between the CPU config port / DMNI Hermes engine and ni_cmdq.
// The slave modport is the command queue's view; the master modport is the
// view of whatever drives the CPU side and models the Hermes engine.
interface ni_cmdq_if #(
    parameter int HERMES_FLIT_SIZE = 32
);
    // CPU memory-mapped config port
    logic                        cfg_we_i;
    logic [3:0]                  cfg_addr_i;
    logic [31:0]                 cfg_data_i;
    logic [31:0]                 cfg_data_o;
    logic                        irq_o;

    // Hermes receive-side status levels
    logic                        hermes_receive_available_i;
    logic [HERMES_FLIT_SIZE-1:0] hermes_receive_flits_available_i;
    logic                        br_svc_rx_i;

    // Descriptor handshake towards the DMNI Hermes engine
    logic                        hermes_req_o;
    logic                        hermes_ack_i;
    logic                        hermes_done_i;
    logic                        hermes_operation_o;
    logic [31:0]                 hermes_size_o;
    logic [31:0]                 hermes_size_2_o;
    logic [31:0]                 hermes_address_o;
    logic [31:0]                 hermes_address_2_o;

    modport slave (
        input  cfg_we_i, cfg_addr_i, cfg_data_i,
        input  hermes_receive_available_i, hermes_receive_flits_available_i, br_svc_rx_i,
        input  hermes_ack_i, hermes_done_i,
        output cfg_data_o, irq_o,
        output hermes_req_o, hermes_operation_o,
        output hermes_size_o, hermes_size_2_o, hermes_address_o, hermes_address_2_o
    );

    modport master (
        output cfg_we_i, cfg_addr_i, cfg_data_i,
        output hermes_receive_available_i, hermes_receive_flits_available_i, br_svc_rx_i,
        output hermes_ack_i, hermes_done_i,
        input  cfg_data_o, irq_o,
        input  hermes_req_o, hermes_operation_o,
        input  hermes_size_o, hermes_size_2_o, hermes_address_o, hermes_address_2_o
    );
endinterface

// File: rtl/ni_cmdq.sv
// NI command queue: the CPU stages Hermes DMA descriptors in registers and
// pushes them into a circular queue; a three-state dispatcher hands them to
// the DMNI engine one at a time over req/ack/done. Also hosts a sticky,
// maskable IRQ block and a 16-bit completion counter.
module ni_cmdq #(
    parameter int HERMES_FLIT_SIZE = 32,
    parameter int CMDQ_DEPTH       = 4
) (
    input  logic    clk_i,
    input  logic    rst_i,
    ni_cmdq_if.slave bus
);
    localparam int PTR_W  = (CMDQ_DEPTH > 1) ? $clog2(CMDQ_DEPTH) : 1;
    localparam int CNT_W  = $clog2(CMDQ_DEPTH + 1);
    localparam int DESC_W = 129;

    localparam logic [3:0] A_STATUS     = 4'd0;
    localparam logic [3:0] A_IRQ_STATUS = 4'd1;
    localparam logic [3:0] A_IRQ_MASK   = 4'd2;
    localparam logic [3:0] A_FLITS      = 4'd3;
    localparam logic [3:0] A_CMD_OP     = 4'd4;
    localparam logic [3:0] A_CMD_SIZE   = 4'd5;
    localparam logic [3:0] A_CMD_SIZE_2 = 4'd6;
    localparam logic [3:0] A_CMD_ADDR   = 4'd7;
    localparam logic [3:0] A_CMD_ADDR_2 = 4'd8;
    localparam logic [3:0] A_CMD_PUSH   = 4'd9;
    localparam logic [3:0] A_DONE_COUNT = 4'd10;
    localparam logic [3:0] A_FLUSH      = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Staging registers (CPU view of the next descriptor)
    logic        op_stage_reg;
    logic [31:0] size_stage_reg, size2_stage_reg, addr_stage_reg, addr2_stage_reg;

    // Descriptor currently presented to the engine
    logic        op_out_reg;
    logic [31:0] size_out_reg, size2_out_reg, addr_out_reg, addr2_out_reg;

    // Queue storage and bookkeeping
    logic [DESC_W-1:0] q_mem [CMDQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              q_empty, q_full;

    // IRQ, mask and completion counter
    logic        done_sticky_reg, ovf_sticky_reg;
    logic [3:0]  irq_mask_reg;
    logic [3:0]  irq_status;
    logic [3:0]  irq_masked;
    logic [15:0] done_cnt_reg;
    logic [15:0] done_cnt_next;

    // Decoded strobes
    logic wr_en, push, push_ok, flush, done_clr, w1c_done, w1c_ovf;
    logic pop, complete;
    logic [DESC_W-1:0] push_desc, head_desc;

    assign wr_en    = bus.cfg_we_i;
    assign push     = wr_en && (bus.cfg_addr_i == A_CMD_PUSH);
    assign flush    = wr_en && (bus.cfg_addr_i == A_FLUSH);
    assign done_clr = wr_en && (bus.cfg_addr_i == A_DONE_COUNT);
    assign w1c_done = wr_en && (bus.cfg_addr_i == A_IRQ_STATUS) && bus.cfg_data_i[2];
    assign w1c_ovf  = wr_en && (bus.cfg_addr_i == A_IRQ_STATUS) && bus.cfg_data_i[3];

    assign q_empty  = (count_reg == '0);
    assign q_full   = (count_reg == CNT_W'(CMDQ_DEPTH));
    // A pop in the same cycle never makes room for a push against a full queue.
    assign push_ok  = push && !q_full;

    assign push_desc = {op_stage_reg, size_stage_reg, size2_stage_reg,
                        addr_stage_reg, addr2_stage_reg};
    assign head_desc = q_mem[rd_ptr_reg];

    // Dispatcher next-state: pop in IDLE, wait for ack in REQ, wait for done in RUN.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        complete   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!q_empty) begin
                    pop        = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.hermes_ack_i) begin
                    if (bus.hermes_done_i) begin
                        complete   = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (bus.hermes_done_i) begin
                    complete   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Dispatcher state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Queue occupancy: flush wins over everything, push+pop together cancel.
    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else if (push_ok && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!push_ok && pop) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    // Queue pointers and count; pointers wrap naturally since depth is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    // Queue storage, no reset so it maps onto RAM.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            q_mem[wr_ptr_reg] <= push_desc;
        end
    end

    // Descriptor output registers: loaded on pop, held until the next pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_out_reg    <= 1'b0;
            size_out_reg  <= '0;
            size2_out_reg <= '0;
            addr_out_reg  <= '0;
            addr2_out_reg <= '0;
        end else if (pop) begin
            {op_out_reg, size_out_reg, size2_out_reg, addr_out_reg, addr2_out_reg} <= head_desc;
        end
    end

    // CPU-writable staging and mask registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_stage_reg    <= 1'b0;
            size_stage_reg  <= '0;
            size2_stage_reg <= '0;
            addr_stage_reg  <= '0;
            addr2_stage_reg <= '0;
            irq_mask_reg    <= '0;
        end else if (wr_en) begin
            case (bus.cfg_addr_i)
                A_IRQ_MASK:   irq_mask_reg    <= bus.cfg_data_i[3:0];
                A_CMD_OP:     op_stage_reg    <= bus.cfg_data_i[0];
                A_CMD_SIZE:   size_stage_reg  <= bus.cfg_data_i;
                A_CMD_SIZE_2: size2_stage_reg <= bus.cfg_data_i;
                A_CMD_ADDR:   addr_stage_reg  <= bus.cfg_data_i;
                A_CMD_ADDR_2: addr2_stage_reg <= bus.cfg_data_i;
                default: ;
            endcase
        end
    end

    // Sticky IRQ bits: a hardware set in the same cycle as a W1C wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_sticky_reg <= 1'b0;
            ovf_sticky_reg  <= 1'b0;
        end else begin
            if (complete)      done_sticky_reg <= 1'b1;
            else if (w1c_done) done_sticky_reg <= 1'b0;
            if (push && q_full) ovf_sticky_reg <= 1'b1;
            else if (w1c_ovf)   ovf_sticky_reg <= 1'b0;
        end
    end

    // A write clears the counter; a completion in the same cycle still counts.
    assign done_cnt_next = (done_clr ? 16'd0 : done_cnt_reg) + {15'd0, complete};

    // Completion counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_cnt_reg <= '0;
        end else begin
            done_cnt_reg <= done_cnt_next;
        end
    end

    assign irq_status = {ovf_sticky_reg, done_sticky_reg,
                         bus.br_svc_rx_i, bus.hermes_receive_available_i};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_irq_mask
            assign irq_masked[gi] = irq_status[gi] & irq_mask_reg[gi];
        end
    endgenerate

    assign bus.irq_o              = |irq_masked;
    assign bus.hermes_req_o       = (state_reg == ST_REQ);
    assign bus.hermes_operation_o = op_out_reg;
    assign bus.hermes_size_o      = size_out_reg;
    assign bus.hermes_size_2_o    = size2_out_reg;
    assign bus.hermes_address_o   = addr_out_reg;
    assign bus.hermes_address_2_o = addr2_out_reg;

    // Combinational read mux for the config port.
    always_comb begin
        logic [31:0] status_word;
        logic [31:0] flits_word;
        status_word = '0;
        status_word[0] = (state_reg != ST_IDLE);
        status_word[1] = q_empty;
        status_word[2] = q_full;
        status_word[8 +: CNT_W] = count_reg;
        flits_word = '0;
        flits_word[HERMES_FLIT_SIZE-1:0] = bus.hermes_receive_flits_available_i;

        bus.cfg_data_o = '0;
        case (bus.cfg_addr_i)
            A_STATUS:     bus.cfg_data_o = status_word;
            A_IRQ_STATUS: bus.cfg_data_o = {28'd0, irq_status};
            A_IRQ_MASK:   bus.cfg_data_o = {28'd0, irq_mask_reg};
            A_FLITS:      bus.cfg_data_o = flits_word;
            A_CMD_OP:     bus.cfg_data_o = {31'd0, op_stage_reg};
            A_CMD_SIZE:   bus.cfg_data_o = size_stage_reg;
            A_CMD_SIZE_2: bus.cfg_data_o = size2_stage_reg;
            A_CMD_ADDR:   bus.cfg_data_o = addr_stage_reg;
            A_CMD_ADDR_2: bus.cfg_data_o = addr2_stage_reg;
            A_DONE_COUNT: bus.cfg_data_o = {16'd0, done_cnt_reg};
            default:      bus.cfg_data_o = '0;
        endcase
    end
endmodule
